nn_layer_sequencer: RTL

Control FSM for the fixed-topology MLP datapath. It walks layer → neuron → input and, per cycle, drives weight/bias ROM addresses, activation ping-pong buffer addresses/banks and MAC strobes. It sits between the host start/done interface and the shared MAC + ReLU + activation-buffer datapath. Topology comes from nn_pkg: NUM_LAYERS, NEURONS_PER_LAYER, NUM_WEIGHTS, NUM_BIASES and MAX_LAYER_DEPTH.

---
 rtl/nn_pkg.sv | 63 ++++++
 rtl/nn_layer_sequencer_if.sv | 33 +++
 rtl/nn_strobe_delay.sv | 30 +++
 rtl/nn_layer_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared MLP topology, derived address widths and sequencer types.
package nn_pkg;

    localparam int unsigned NUM_LAYERS      = 5;
    localparam int unsigned MAX_LAYER_DEPTH = 16;
    localparam int unsigned NEURONS_PER_LAYER [NUM_LAYERS] = '{1, 15, 15, 15, 2};

    function automatic int unsigned calc_num_weights();
        int unsigned acc;
        acc = 0;
        for (int unsigned l = 1; l < NUM_LAYERS; l++)
            acc += NEURONS_PER_LAYER[l-1] * NEURONS_PER_LAYER[l];
        return acc;
    endfunction

    function automatic int unsigned calc_num_biases();
        int unsigned acc;
        acc = 0;
        for (int unsigned l = 1; l < NUM_LAYERS; l++)
            acc += NEURONS_PER_LAYER[l];
        return acc;
    endfunction

    localparam int unsigned NUM_WEIGHTS = calc_num_weights();
    localparam int unsigned NUM_BIASES  = calc_num_biases();
    localparam int unsigned W_ADDR_W    = $clog2(NUM_WEIGHTS);
    localparam int unsigned B_ADDR_W    = $clog2(NUM_BIASES);
    localparam int unsigned A_ADDR_W    = $clog2(MAX_LAYER_DEPTH);
    localparam int unsigned CNT_W       = A_ADDR_W + 1;
    localparam int unsigned LAYER_W     = 3;

    // Cycles from the accepting edge to the done cycle for a given memory latency.
    function automatic int unsigned seq_cycles(input int unsigned mem_latency);
        return NUM_WEIGHTS + NUM_BIASES + (NUM_LAYERS - 1) * (mem_latency + 1) + 1;
    endfunction

    localparam int unsigned TOTAL_SEQ_CYCLES = seq_cycles(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic                mac_clr;
        logic                mac_en;
        logic                bias_en;
        logic                relu_en;
        logic [A_ADDR_W-1:0] act_wr_addr;
        logic                act_wr_bank;
    } strobe_t;

    function automatic logic [CNT_W-1:0] layer_size(input logic [LAYER_W-1:0] l);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++)
            if (LAYER_W'(k) == l) r = CNT_W'(NEURONS_PER_LAYER[k]);
        return r;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Host start/done handshake plus ROM/activation/MAC control bus of the sequencer.
interface nn_layer_sequencer_if;
    import nn_pkg::*;

    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic [W_ADDR_W-1:0] w_addr;
    logic [B_ADDR_W-1:0] b_addr;
    logic [A_ADDR_W-1:0] act_rd_addr;
    logic                act_rd_bank;
    logic [A_ADDR_W-1:0] act_wr_addr;
    logic                act_wr_bank;
    logic                mac_clr;
    logic                mac_en;
    logic                bias_en;
    logic                relu_en;
    logic [2:0]          layer_idx;

    modport master (
        output start, abort,
        input  busy, done, w_addr, b_addr, act_rd_addr, act_rd_bank,
               act_wr_addr, act_wr_bank, mac_clr, mac_en, bias_en, relu_en, layer_idx
    );

    modport slave (
        input  start, abort,
        output busy, done, w_addr, b_addr, act_rd_addr, act_rd_bank,
               act_wr_addr, act_wr_bank, mac_clr, mac_en, bias_en, relu_en, layer_idx
    );

endinterface

// File: rtl/nn_strobe_delay.sv
// Fixed-depth delay pipe aligning datapath strobes with memory read data.
module nn_strobe_delay
    import nn_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  strobe_t din,
    output strobe_t dout
);

    strobe_t [DEPTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int unsigned k = 1; k < DEPTH; k++)
                pipe[k] <= pipe[k-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer/neuron/input walker driving ROM and activation addresses and delayed MAC strobes.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic                clk,
    input logic                rst_n,
    nn_layer_sequencer_if.slave bus
);

    localparam int unsigned DRAIN_W = 3;

    seq_state_t          state, state_d;
    logic [LAYER_W-1:0]  layer, layer_d;
    logic [A_ADDR_W-1:0] n, n_d;
    logic [A_ADDR_W-1:0] i, i_d;
    logic [W_ADDR_W-1:0] w_addr, w_addr_d;
    logic [B_ADDR_W-1:0] b_addr, b_addr_d;
    logic [DRAIN_W-1:0]  drain, drain_d;
    logic                rd_bank, rd_bank_d;
    logic                busy, busy_d;
    logic                done, done_d;
    logic [CNT_W-1:0]    n_in, n_out;
    logic                is_bias, last_neuron, last_layer;
    strobe_t             raw, dly;

    assign n_in        = layer_size(layer - LAYER_W'(1));
    assign n_out       = layer_size(layer);
    assign is_bias     = (CNT_W'(i) == n_in);
    assign last_neuron = (CNT_W'(n) == n_out - CNT_W'(1));
    assign last_layer  = (layer == LAYER_W'(NUM_LAYERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            layer   <= '0;
            n       <= '0;
            i       <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
            drain   <= '0;
            rd_bank <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            layer   <= layer_d;
            n       <= n_d;
            i       <= i_d;
            w_addr  <= w_addr_d;
            b_addr  <= b_addr_d;
            drain   <= drain_d;
            rd_bank <= rd_bank_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // One MAC per input, then one bias/writeback cycle per neuron; drain between layers.
    always_comb begin
        state_d   = state;
        layer_d   = layer;
        n_d       = n;
        i_d       = i;
        w_addr_d  = w_addr;
        b_addr_d  = b_addr;
        drain_d   = drain;
        rd_bank_d = rd_bank;
        raw       = '0;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_d   = ISSUE;
                        layer_d   = LAYER_W'(1);
                        n_d       = '0;
                        i_d       = '0;
                        w_addr_d  = '0;
                        b_addr_d  = '0;
                        rd_bank_d = 1'b0;
                    end
                end
                ISSUE: begin
                    if (!is_bias) begin
                        raw.mac_en  = 1'b1;
                        raw.mac_clr = (i == '0);
                        w_addr_d    = w_addr + W_ADDR_W'(1);
                        i_d         = i + A_ADDR_W'(1);
                    end else begin
                        raw.bias_en     = 1'b1;
                        raw.relu_en     = !last_layer;
                        raw.act_wr_addr = n;
                        raw.act_wr_bank = ~rd_bank;
                        b_addr_d        = b_addr + B_ADDR_W'(1);
                        i_d             = '0;
                        if (last_neuron) begin
                            state_d = DRAIN;
                            drain_d = '0;
                            n_d     = '0;
                        end else begin
                            n_d = n + A_ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Hold off the next layer until the last writeback has landed.
                    if (drain == DRAIN_W'(MEM_LATENCY)) begin
                        if (last_layer) begin
                            state_d = DONE;
                        end else begin
                            state_d   = ISSUE;
                            layer_d   = layer + LAYER_W'(1);
                            rd_bank_d = ~rd_bank;
                        end
                    end else begin
                        drain_d = drain + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    nn_strobe_delay #(
        .DEPTH (MEM_LATENCY)
    ) u_strobe_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.abort),
        .din   (raw),
        .dout  (dly)
    );

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.w_addr      = w_addr;
    assign bus.b_addr      = b_addr;
    assign bus.act_rd_addr = i;
    assign bus.act_rd_bank = rd_bank;
    assign bus.act_wr_addr = dly.act_wr_addr;
    assign bus.act_wr_bank = dly.act_wr_bank;
    assign bus.mac_clr     = dly.mac_clr;
    assign bus.mac_en      = dly.mac_en;
    assign bus.bias_en     = dly.bias_en;
    assign bus.relu_en     = dly.relu_en;
    assign bus.layer_idx   = layer;

endmodule
